// File: rtl/alu_share_pkg.sv
// Shared types and widths for the ALU sharing controller.
//   state_t : controller FSM states
//   OPW     : opcode width
//   DW      : ALU data width
package alu_share_pkg;

   localparam int OPW = 8;
   localparam int DW  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Picks the first asserted request at or after ptr, wrapping NREQ-1 -> 0.
//   req       : request vector
//   ptr       : highest-priority index for this decision
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted requester (0 when no request)
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx
);

   always_comb begin
      int   idx;
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one 8-bit ALU between NREQ requesters: round-robin accept, one op in
// flight, start/done handshake with the ALU and a per-op timeout.
//
// state | meaning
// IDLE  | arbitrate; accept winner, latch op and owner
// ISSUE | pulse alu_start, clear timeout counter
// WAIT  | wait for alu_done or timeout
// RESP  | pulse resp_valid to owner
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid / req_ready           per-requester handshake (ready one-hot, IDLE only)
//   req_opcode / req_a / req_b      packed per-requester op fields, requester i at [8i+7:8i]
//   resp_valid                      one-hot response pulse to the op owner
//   resp_result/carry/borrow/err    registered response fields, hold after the pulse
//   alu_start                       one-cycle start to ALU
//   alu_opcode / alu_a / alu_b      latched op, stable while the op is in flight
//   alu_done/result/carry/borrow    ALU completion inputs
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [OPW*NREQ-1:0] req_opcode,
   input  logic [DW*NREQ-1:0]  req_a,
   input  logic [DW*NREQ-1:0]  req_b,
   output logic [NREQ-1:0]   resp_valid,
   output logic [DW-1:0]     resp_result,
   output logic              resp_carry,
   output logic              resp_borrow,
   output logic              resp_err,
   output logic              alu_start,
   output logic [OPW-1:0]    alu_opcode,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   input  logic              alu_done,
   input  logic [DW-1:0]     alu_result,
   input  logic              alu_carry,
   input  logic              alu_borrow
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);

   state_t           state_q, state_d;
   logic [PW-1:0]    rr_ptr_q;
   logic [PW-1:0]    owner_q;
   logic [CW-1:0]    cnt_q;
   logic [NREQ-1:0]  grant;
   logic [PW-1:0]    grant_idx;
   logic [PW-1:0]    ptr_next;
   logic             accept;
   logic             done_hit;
   logic             tmo_hit;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      resp_valid = '0;
      alu_start  = 1'b0;
      accept     = 1'b0;
      done_hit   = 1'b0;
      tmo_hit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready = grant;
               accept    = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            alu_start = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            // done takes priority over a timeout landing in the same cycle
            if (alu_done) begin
               done_hit = 1'b1;
               state_d  = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               tmo_hit = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid[owner_q] = 1'b1;
            state_d             = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // keep every output quiet while reset is held, whatever state we were in
      if (rst) begin
         req_ready  = '0;
         resp_valid = '0;
         alu_start  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         alu_opcode  <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         resp_result <= '0;
         resp_carry  <= 1'b0;
         resp_borrow <= 1'b0;
         resp_err    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            alu_opcode <= req_opcode[grant_idx*OPW +: OPW];
            alu_a      <= req_a[grant_idx*DW +: DW];
            alu_b      <= req_b[grant_idx*DW +: DW];
            owner_q    <= grant_idx;
            rr_ptr_q   <= ptr_next;
         end
         if (state_q == ISSUE) begin
            cnt_q <= '0;
         end else if (state_q == WAIT && !done_hit && !tmo_hit) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (done_hit) begin
            resp_result <= alu_result;
            resp_carry  <= alu_carry;
            resp_borrow <= alu_borrow;
            resp_err    <= 1'b0;
         end else if (tmo_hit) begin
            resp_result <= '0;
            resp_carry  <= 1'b0;
            resp_borrow <= 1'b0;
            resp_err    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

   localparam int NREQ    = 3;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [8*NREQ-1:0] req_opcode;
   logic [8*NREQ-1:0] req_a;
   logic [8*NREQ-1:0] req_b;
   logic [NREQ-1:0]   resp_valid;
   logic [7:0]        resp_result;
   logic              resp_carry;
   logic              resp_borrow;
   logic              resp_err;
   logic              alu_start;
   logic [7:0]        alu_opcode;
   logic [7:0]        alu_a;
   logic [7:0]        alu_b;
   logic              alu_done;
   logic [7:0]        alu_result;
   logic              alu_carry;
   logic              alu_borrow;

   int n_chk = 0;
   int n_err = 0;

   alu_share_ctrl #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_opcode  (req_opcode),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_valid  (resp_valid),
      .resp_result (resp_result),
      .resp_carry  (resp_carry),
      .resp_borrow (resp_borrow),
      .resp_err    (resp_err),
      .alu_start   (alu_start),
      .alu_opcode  (alu_opcode),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .alu_carry   (alu_carry),
      .alu_borrow  (alu_borrow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      req_opcode[8*i +: 8] = op;
      req_a[8*i +: 8]      = a;
      req_b[8*i +: 8]      = b;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int order[6];
      order = '{0, 1, 2, 0, 1, 2};
      rst        = 1'b1;
      req_valid  = '0;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      alu_done   = 1'b0;
      alu_result = '0;
      alu_carry  = 1'b0;
      alu_borrow = 1'b0;

      // ---- reset state
      tick();
      req_valid = 3'b111;
      #1;
      chk("rst_ready", req_ready, 0);
      tick();
      req_valid = '0;
      rst       = 1'b0;
      #1;
      chk("rst_ready_idle", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_alu_start", alu_start, 0);
      chk("rst_alu_opcode", alu_opcode, 0);
      chk("rst_resp_result", resp_result, 0);
      chk("rst_resp_err", resp_err, 0);

      // ---- test 1: single ADD from req0, done one cycle after start
      set_req(0, 8'h01, 8'd5, 8'd3);
      req_valid = 3'b001;
      #1;
      chk("t1_ready", req_ready, 3'b001);
      tick();
      req_valid = '0;
      #1;
      chk("t1_start", alu_start, 1);
      chk("t1_ready_busy", req_ready, 0);
      chk("t1_opcode", alu_opcode, 8'h01);
      chk("t1_a", alu_a, 8'd5);
      chk("t1_b", alu_b, 8'd3);
      tick();
      chk("t1_start_once", alu_start, 0);
      alu_done   = 1'b1;
      alu_result = 8'd8;
      tick();
      alu_done = 1'b0;
      #1;
      chk("t1_resp_valid", resp_valid, 3'b001);
      chk("t1_result", resp_result, 8'd8);
      chk("t1_err", resp_err, 0);
      tick();
      chk("t1_resp_pulse", resp_valid, 0);
      chk("t1_result_hold", resp_result, 8'd8);

      // ---- test 2: all three valid continuously, round-robin order
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(0, 8'h10, 8'd1, 8'd1);
      set_req(1, 8'h11, 8'd2, 8'd2);
      set_req(2, 8'h12, 8'd3, 8'd3);
      req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("t2_ready_%0d", i), req_ready, 32'(1) << order[i]);
         tick();
         chk($sformatf("t2_opcode_%0d", i), alu_opcode, 32'h10 + order[i]);
         chk($sformatf("t2_busy_%0d", i), req_ready, 0);
         tick();
         alu_done   = 1'b1;
         alu_result = 8'(8'h40 + i);
         tick();
         alu_done = 1'b0;
         #1;
         chk($sformatf("t2_resp_%0d", i), resp_valid, 32'(1) << order[i]);
         chk($sformatf("t2_result_%0d", i), resp_result, 32'h40 + i);
         tick();
      end
      req_valid = '0;

      // ---- test 3: timeout, then late done ignored (pointer now 0)
      set_req(1, 8'h21, 8'd9, 8'd9);
      req_valid = 3'b010;
      #1;
      chk("t3_ready", req_ready, 3'b010);
      tick();
      req_valid  = '0;
      alu_result = 8'hAA;
      alu_carry  = 1'b1;
      tick();
      n = 0;
      while (resp_valid == 0 && n < 40) begin
         tick();
         n++;
      end
      chk("t3_wait_cycles", n, TIMEOUT);
      chk("t3_resp_valid", resp_valid, 3'b010);
      chk("t3_err", resp_err, 1);
      chk("t3_result", resp_result, 0);
      chk("t3_carry", resp_carry, 0);
      tick();
      alu_done = 1'b1;
      #1;
      chk("t3_late_start", alu_start, 0);
      tick();
      alu_done  = 1'b0;
      alu_carry = 1'b0;
      #1;
      chk("t3_late_start2", alu_start, 0);
      chk("t3_late_resp", resp_valid, 0);
      chk("t3_err_hold", resp_err, 1);

      // ---- test 4: done on the last timeout cycle wins (pointer now 2)
      set_req(0, 8'h31, 8'd7, 8'd7);
      req_valid = 3'b001;
      #1;
      chk("t4_ready", req_ready, 3'b001);
      tick();
      req_valid = '0;
      tick();
      for (int k = 1; k < TIMEOUT; k++) tick();
      chk("t4_no_early_resp", resp_valid, 0);
      alu_done   = 1'b1;
      alu_result = 8'h5A;
      alu_carry  = 1'b1;
      tick();
      alu_done  = 1'b0;
      alu_carry = 1'b0;
      #1;
      chk("t4_resp_valid", resp_valid, 3'b001);
      chk("t4_err", resp_err, 0);
      chk("t4_result", resp_result, 8'h5A);
      chk("t4_carry", resp_carry, 1);
      tick();

      // ---- test 5: reset in WAIT aborts the op (pointer now 1)
      set_req(0, 8'h33, 8'd4, 8'd4);
      req_valid = 3'b001;
      #1;
      chk("t5_ready", req_ready, 3'b001);
      tick();
      req_valid = '0;
      tick();
      rst = 1'b1;
      #1;
      chk("t5_rst_resp", resp_valid, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("t5_opcode", alu_opcode, 0);
      chk("t5_a", alu_a, 0);
      chk("t5_result", resp_result, 0);
      chk("t5_carry", resp_carry, 0);
      chk("t5_start", alu_start, 0);
      n = 0;
      alu_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (resp_valid != 0) n++;
         tick();
      end
      alu_done = 1'b0;
      chk("t5_no_resp", n, 0);
      set_req(0, 8'h01, 8'd1, 8'd1);
      set_req(1, 8'h02, 8'd2, 8'd2);
      set_req(2, 8'h03, 8'd3, 8'd3);
      req_valid = 3'b111;
      #1;
      chk("t5_grant_req0", req_ready, 3'b001);
      tick();
      req_valid = '0;
      tick();
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      tick();

      // ---- test 6: signed SUB from req2, operand stability (pointer now 1)
      set_req(2, 8'h02, 8'h80, 8'h01);
      req_valid = 3'b100;
      #1;
      chk("t6_ready", req_ready, 3'b100);
      tick();
      req_valid = '0;
      set_req(2, 8'hFF, 8'h11, 8'h22);
      #1;
      chk("t6_a", alu_a, 8'h80);
      chk("t6_b", alu_b, 8'h01);
      chk("t6_opcode", alu_opcode, 8'h02);
      tick();
      tick();
      chk("t6_a_stable", alu_a, 8'h80);
      alu_done   = 1'b1;
      alu_result = 8'h7F;
      alu_borrow = 1'b1;
      alu_carry  = 1'b0;
      tick();
      alu_done   = 1'b0;
      alu_borrow = 1'b0;
      #1;
      chk("t6_resp_valid", resp_valid, 3'b100);
      chk("t6_result", resp_result, 8'h7F);
      chk("t6_borrow", resp_borrow, 1);
      chk("t6_carry", resp_carry, 0);
      chk("t6_err", resp_err, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
